// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state encoding and AXI field widths for the read arbiter.
package axi_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;
    localparam int BEAT_W  = 9;
endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; a sole requester always wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);
    assign grant_o = (&req_i) ? ~last_i : req_i[1];
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read port between fetch L1 (s0) and LSU L1 (s1),
// one burst outstanding at a time, with round-robin grant between bursts.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s0_arvalid,
    output logic               s0_arready,
    input  logic [ADDR_W-1:0]  s0_araddr,
    input  logic [LEN_W-1:0]   s0_arlen,
    input  logic [SIZE_W-1:0]  s0_arsize,
    input  logic [BURST_W-1:0] s0_arburst,
    input  logic [CACHE_W-1:0] s0_arcache,
    input  logic [PROT_W-1:0]  s0_arprot,
    input  logic               s1_arvalid,
    output logic               s1_arready,
    input  logic [ADDR_W-1:0]  s1_araddr,
    input  logic [LEN_W-1:0]   s1_arlen,
    input  logic [SIZE_W-1:0]  s1_arsize,
    input  logic [BURST_W-1:0] s1_arburst,
    input  logic [CACHE_W-1:0] s1_arcache,
    input  logic [PROT_W-1:0]  s1_arprot,
    output logic               s0_rvalid,
    input  logic               s0_rready,
    output logic               s1_rvalid,
    input  logic               s1_rready,
    output logic [DATA_W-1:0]  s_rdata,
    output logic [RESP_W-1:0]  s_rresp,
    output logic               s_rlast,
    output logic               m_arvalid,
    input  logic               m_arready,
    output logic [ADDR_W-1:0]  m_araddr,
    output logic [LEN_W-1:0]   m_arlen,
    output logic [SIZE_W-1:0]  m_arsize,
    output logic [BURST_W-1:0] m_arburst,
    output logic [CACHE_W-1:0] m_arcache,
    output logic [PROT_W-1:0]  m_arprot,
    input  logic               m_rvalid,
    output logic               m_rready,
    input  logic [DATA_W-1:0]  m_rdata,
    input  logic [RESP_W-1:0]  m_rresp,
    input  logic               m_rlast,
    output logic               busy,
    output logic               len_err
);
    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [BEAT_W-1:0]  beats_q, beats_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               len_err_q, len_err_d;
    logic               rr_grant;
    logic               in_addr, in_data;

    rr_arb2 u_rr (
        .req_i   ({s1_arvalid, s0_arvalid}),
        .last_i  (last_q),
        .grant_o (rr_grant)
    );

    assign in_addr = state_q == ADDR;
    assign in_data = state_q == DATA;

    // Address payload is muxed on the registered grant, never registered itself.
    assign m_arvalid  = in_addr & (grant_q ? s1_arvalid : s0_arvalid);
    assign m_araddr   = grant_q ? s1_araddr  : s0_araddr;
    assign m_arlen    = grant_q ? s1_arlen   : s0_arlen;
    assign m_arsize   = grant_q ? s1_arsize  : s0_arsize;
    assign m_arburst  = grant_q ? s1_arburst : s0_arburst;
    assign m_arcache  = grant_q ? s1_arcache : s0_arcache;
    assign m_arprot   = grant_q ? s1_arprot  : s0_arprot;
    assign s0_arready = in_addr & ~grant_q & m_arready;
    assign s1_arready = in_addr & grant_q & m_arready;

    assign m_rready  = in_data & (grant_q ? s1_rready : s0_rready);
    assign s0_rvalid = in_data & ~grant_q & m_rvalid;
    assign s1_rvalid = in_data & grant_q & m_rvalid;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;

    assign busy    = state_q != IDLE;
    assign len_err = len_err_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        beats_d   = beats_q;
        len_d     = len_q;
        len_err_d = 1'b0;
        case (state_q)
            IDLE: if (s0_arvalid | s1_arvalid) begin
                grant_d = rr_grant;
                state_d = ADDR;
            end
            ADDR: if (m_arvalid & m_arready) begin
                len_d   = m_arlen;
                beats_d = '0;
                state_d = DATA;
            end
            DATA: if (m_rvalid & m_rready) begin
                beats_d = beats_q + 9'd1;
                if (m_rlast) begin
                    state_d   = IDLE;
                    last_d    = grant_q;
                    len_err_d = beats_d != ({1'b0, len_q} + 9'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            beats_q   <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            beats_q   <= beats_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: random requesters and memory checked against a transaction-level model.
module tb_axi_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    arv = '0, arrdy, rv, rrdy = '0;
    logic [AW-1:0] araddr[2];
    logic [7:0]    arlen[2];
    logic [2:0]    arsize[2];
    logic [1:0]    arburst[2];
    logic [3:0]    arcache[2];
    logic [2:0]    arprot[2];
    logic [DW-1:0] s_rdata, m_rdata = '0;
    logic [1:0]    s_rresp, m_rresp = '0;
    logic          s_rlast, m_rlast = 1'b0;
    logic          m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize, m_arprot;
    logic [1:0]    m_arburst;
    logic [3:0]    m_arcache;
    logic          busy, len_err;

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .s0_arvalid(arv[0]), .s0_arready(arrdy[0]), .s0_araddr(araddr[0]), .s0_arlen(arlen[0]),
        .s0_arsize(arsize[0]), .s0_arburst(arburst[0]), .s0_arcache(arcache[0]), .s0_arprot(arprot[0]),
        .s1_arvalid(arv[1]), .s1_arready(arrdy[1]), .s1_araddr(araddr[1]), .s1_arlen(arlen[1]),
        .s1_arsize(arsize[1]), .s1_arburst(arburst[1]), .s1_arcache(arcache[1]), .s1_arprot(arprot[1]),
        .s0_rvalid(rv[0]), .s0_rready(rrdy[0]), .s1_rvalid(rv[1]), .s1_rready(rrdy[1]),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .busy(busy), .len_err(len_err)
    );

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    // Reference model: phase 0 waiting, 1 address offered, 2 burst in flight.
    int ph = 0, mlen = 0, mbeats = 0, mem_total = 0, mem_sent = 0, cyc = 0, rlast_cyc = -1;
    bit g = 0, last = 1, lerr = 0, gap_chk = 0;
    bit [1:0] done_ar = '0;
    int p_req[2] = '{0, 0};
    int p_ar = 100, p_rv = 100, p_rr = 100, p_err = 0, force_len = -1, force_total = -1;
    int grant_log[$];
    int obs[2] = '{0, 0};
    int n_lerr = 0;

    task automatic cycle(input bit rst);
        @(negedge clk);
        reset = rst;
        arv &= ~done_ar;
        done_ar = '0;
        for (int n = 0; n < 2; n++) begin
            if (rst) arv[n] = 1'b0;
            else if (!arv[n] && $urandom_range(99) < p_req[n]) begin
                arv[n]     = 1'b1;
                araddr[n]  = $urandom;
                arlen[n]   = (force_len >= 0) ? 8'(force_len) : 8'($urandom_range(7));
                arsize[n]  = 3'($urandom);
                arburst[n] = 2'($urandom);
                arcache[n] = 4'($urandom);
                arprot[n]  = 3'($urandom);
            end
            rrdy[n] = $urandom_range(99) < p_rr;
        end
        m_arready = $urandom_range(99) < p_ar;
        m_rvalid  = $urandom_range(99) < p_rv;
        m_rdata   = {$urandom, $urandom};
        m_rresp   = 2'($urandom);
        m_rlast   = (ph == 2) ? (mem_sent == mem_total - 1) : 1'($urandom);
        #1;
        check("busy", busy, ph != 0);
        check("len_err", len_err, lerr);
        check("ar_hs", {m_arvalid, arrdy[1], arrdy[0]},
              {ph == 1 && arv[g], ph == 1 && g && m_arready, ph == 1 && !g && m_arready});
        if (ph == 1)
            check("ar_payload", {m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_arprot},
                  {araddr[g], arlen[g], arsize[g], arburst[g], arcache[g], arprot[g]});
        check("r_hs", {m_rready, rv[1], rv[0]},
              {ph == 2 && rrdy[g], ph == 2 && g && m_rvalid, ph == 2 && !g && m_rvalid});
        check("r_payload", {s_rdata, s_rresp, s_rlast}, {m_rdata, m_rresp, m_rlast});
        for (int n = 0; n < 2; n++) if (rv[n] && rrdy[n]) obs[n]++;
        if (len_err) n_lerr++;
        if (rst) begin
            ph = 0; last = 1; lerr = 0; mem_sent = 0;
        end else begin
            lerr = 0;
            case (ph)
                0: if (|arv) begin
                    g  = (&arv) ? !last : arv[1];
                    ph = 1;
                end
                1: if (m_arready) begin
                    mlen = arlen[g]; mbeats = 0; mem_sent = 0; ph = 2;
                    done_ar[g] = 1'b1;
                    grant_log.push_back(int'(g));
                    if (gap_chk && rlast_cyc >= 0) check("rlast_to_ar_gap", cyc - rlast_cyc, 2);
                    mem_total = (force_total > 0) ? force_total :
                                ($urandom_range(99) < p_err) ? $urandom_range(mlen + 3, 1) : mlen + 1;
                end
                default: if (m_rvalid && rrdy[g]) begin
                    mbeats++; mem_sent++;
                    if (m_rlast) begin
                        lerr = mbeats != mlen + 1;
                        last = g; ph = 0; rlast_cyc = cyc;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic clear_stats();
        obs = '{0, 0}; n_lerr = 0; grant_log.delete(); rlast_cyc = -1;
    endtask

    initial begin
        araddr = '{0, 0}; arlen = '{0, 0}; arsize = '{0, 0};
        arburst = '{0, 0}; arcache = '{0, 0}; arprot = '{0, 0};
        repeat (3) cycle(1);
        cycle(0);

        // s0 alone, 8-beat burst
        clear_stats(); force_len = 7;
        p_req = '{100, 0}; cycle(0); p_req = '{0, 0};
        repeat (30) cycle(0);
        check("s0_beats", obs[0], 8);
        check("s1_beats", obs[1], 0);
        check("single_ar", grant_log.size(), 1);
        check("lenerr_none", n_lerr, 0);

        // both held: s0 first, alternation, fixed 2-cycle gap
        cycle(1); clear_stats(); force_len = 3; gap_chk = 1;
        p_req = '{100, 100};
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) cycle(0);
        check("four_bursts", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("grant%0d", i), grant_log[i], i % 2);
        p_req = '{0, 0}; gap_chk = 0;
        repeat (20) cycle(0);

        // short burst: rlast on beat 2 of 4
        cycle(1); clear_stats(); force_total = 2;
        p_req = '{100, 0}; cycle(0); p_req = '{0, 0};
        repeat (20) cycle(0);
        check("lenerr_pulse", n_lerr, 1);
        check("short_beats", obs[0], 2);
        force_total = -1;

        // reset mid-burst after the first beat
        force_len = 7;
        p_req = '{0, 100}; cycle(0); p_req = '{0, 0};
        for (int i = 0; i < 50 && !(ph == 2 && mem_sent == 1); i++) cycle(0);
        check("reached_beat1", ph == 2 && mem_sent == 1, 1);
        cycle(1);
        repeat (3) cycle(0);
        force_len = -1;

        // random traffic with back-pressure and length errors
        clear_stats();
        p_req = '{40, 40}; p_ar = 60; p_rv = 60; p_rr = 70; p_err = 20;
        repeat (3000) cycle(0);
        check("random_progress", grant_log.size() > 20, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
